// File: rtl/avr_io_uart_txfifo.sv
// avr_io_uart_txfifo
// Byte FIFO between the AVR UDR write path and the UART transmit core.
// The CPU can queue bytes without waiting on UDRE after every write. The
// head byte is offered to the core through tx_data/tx_strobe, and it is
// consumed on the edge where the core loads it: either the core is idle,
// or the core is on its last stop-bit tick (prefetch). Because of the
// prefetch load, back-to-back frames go out without an idle gap.
// Status flags (empty/full/udre/level) come from a registered occupancy
// counter, so wr_en has no combinational path to any flag or to tx_strobe.

module avr_io_uart_txfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    input  logic                  tx_busy,
    input  logic                  tx_prefetch,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe,
    output logic                  empty,
    output logic                  full,
    output logic                  udre,
    output logic                  all_sent,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // Storage and control state
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   level_q,  level_d;
    logic                  overflow_q, overflow_d;

    // Handshake terms for the current cycle
    logic pop;
    logic push;
    logic drop;
    logic do_push;
    logic do_pop;

    // Flags are decoded from the registered occupancy only
    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LEVEL_FULL);
        udre      = ~full;
        tx_strobe = ~empty;
        all_sent  = empty & ~tx_busy;
        level     = level_q;
        overflow  = overflow_q;
        tx_data   = mem_q[rd_ptr_q];
    end

    // Decide what happens at the coming edge: pop, push, drop, flush
    always_comb begin
        pop     = tx_strobe & (~tx_busy | tx_prefetch);
        push    = wr_en & (~full | pop);
        drop    = wr_en & full & ~pop;
        do_push = push & ~flush;
        do_pop  = pop & ~flush;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush) begin
            // Discarding the queue: read side jumps to the write side
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
        end

        // A dropped byte sets the flag and wins over a same-cycle clear;
        // writes lost to a flush are not counted as drops
        if (drop & ~flush) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Next-state for the byte array: only the write slot changes
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_avr_io_uart_txfifo.sv
// Testbench for avr_io_uart_txfifo
// The stimulus process keeps a behavioural model (occupancy count and
// overflow flag) and pushes every byte the FIFO should accept into a
// scoreboard queue. A separate monitor pops that queue whenever the DUT
// hands a byte to the transmit core and compares the byte.

module tb_avr_io_uart_txfifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                flush;
    logic                clr_ovf;
    logic                tx_busy;
    logic                tx_prefetch;
    logic [7:0]          tx_data;
    logic                tx_strobe;
    logic                empty;
    logic                full;
    logic                udre;
    logic                all_sent;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] exp_q[$];
    int         model_level;
    bit         model_ovf;

    avr_io_uart_txfifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .clr_ovf     (clr_ovf),
        .tx_busy     (tx_busy),
        .tx_prefetch (tx_prefetch),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .empty       (empty),
        .full        (full),
        .udre        (udre),
        .all_sent    (all_sent),
        .level       (level),
        .overflow    (overflow)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare all status outputs against the model (called #1 after an edge)
    task automatic checkOutput();
        bit m_empty;
        m_empty = (model_level == 0);
        checkValue("level",     int'(level),     model_level);
        checkValue("empty",     int'(empty),     int'(m_empty));
        checkValue("full",      int'(full),      int'(model_level == DEPTH));
        checkValue("udre",      int'(udre),      int'(model_level != DEPTH));
        checkValue("tx_strobe", int'(tx_strobe), int'(!m_empty));
        checkValue("all_sent",  int'(all_sent),  int'(m_empty && !tx_busy));
        checkValue("overflow",  int'(overflow),  int'(model_ovf));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check flags
    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic fl,
                                 input logic clr, input logic busy, input logic pre);
        bit m_pop, m_full, m_push, m_drop;
        wr_en       = we;
        wr_data     = d;
        flush       = fl;
        clr_ovf     = clr;
        tx_busy     = busy;
        tx_prefetch = pre;

        m_pop  = (model_level > 0) && (!busy || pre);
        m_full = (model_level == DEPTH);
        if (fl) begin
            exp_q.delete();
            model_level = 0;
            if (clr) model_ovf = 1'b0;
        end else begin
            m_push = we && (!m_full || m_pop);
            m_drop = we && m_full && !m_pop;
            if (m_push) exp_q.push_back(d);
            model_level = model_level + int'(m_push) - int'(m_pop);
            if (m_drop)   model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end

        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
        checkOutput();
    endtask

    task automatic doReset();
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        flush       = 1'b0;
        clr_ovf     = 1'b0;
        tx_busy     = 1'b0;
        tx_prefetch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_level = 0;
        model_ovf   = 1'b0;
        checkOutput();
    endtask

    // Monitor: every byte the core loads must be the oldest accepted byte
    always @(negedge clk) begin
        if (!rst && !flush && tx_strobe && (!tx_busy || tx_prefetch)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no byte at %0t", tx_data, $time);
            end else begin
                checkValue("tx_data", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Directed scenarios followed by random traffic
    initial begin
        rst = 1'b1;
        model_level = 0;
        model_ovf   = 1'b0;
        doReset();

        // Single byte through an idle core
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill to full with the core busy, then one dropped write
        for (int i = 1; i <= DEPTH; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Write into a full FIFO on a prefetch edge is accepted
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Pointer wrap with one byte in flight
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush with five bytes queued and a concurrent write
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0);

        // Drop and clear in the same cycle, then clear alone
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic; the core never loads during a flush cycle
        for (int i = 0; i < 800; i++) begin
            logic we, fl, clr, busy, pre;
            we   = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 3);
            clr  = ($urandom_range(0, 99) < 5);
            busy = ($urandom_range(0, 99) < 50);
            pre  = ($urandom_range(0, 99) < 25);
            if (fl) begin
                busy = 1'b1;
                pre  = 1'b0;
            end
            applyStimulus(we, 8'($urandom), fl, clr, busy, pre);
        end

        // Drain with an idle core
        for (int i = 0; i < DEPTH + 2; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("scoreboard_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
